// File: rtl/clic_pkg.sv
// rtl/clic_pkg.sv - shared types and constants for the CLIC interrupt transmitter
package clic_pkg;

    localparam int LevelWidth  = 8;
    localparam int NodeIdWidth = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2
    } clic_state_e;

    // Field order makes a plain unsigned compare rank valid, then level, then id.
    typedef struct packed {
        logic                   valid;
        logic [LevelWidth-1:0]  level;
        logic [NodeIdWidth-1:0] id;
    } clic_node_t;

endpackage

// File: rtl/clic_irq_tx_if.sv
// rtl/clic_irq_tx_if.sv - one-hot interrupt request/ack link between CLIC and core
interface clic_irq_tx_if
    import clic_pkg::*;
#(
    parameter int NumSrc = 64
) ();

    logic [NumSrc-1:0]         irq;
    logic [LevelWidth-1:0]     irq_level;
    logic [$clog2(NumSrc)-1:0] irq_id;
    logic                      irq_ack;

    modport master (output irq, output irq_level, output irq_id, input irq_ack);
    modport slave  (input irq, input irq_level, input irq_id, output irq_ack);

endinterface

// File: rtl/clic_max_tree.sv
// rtl/clic_max_tree.sv - combinational max-tree picking the highest {valid, level, id} source
module clic_max_tree
    import clic_pkg::*;
#(
    parameter int NumSrc  = 64,
    parameter int IdWidth = $clog2(NumSrc)
) (
    input  logic [NumSrc-1:0]            eligible_i,
    input  logic [NumSrc*LevelWidth-1:0] level_i,
    output logic                         valid_o,
    output logic [LevelWidth-1:0]        level_o,
    output logic [IdWidth-1:0]           id_o
);

    localparam int Depth = $clog2(NumSrc);

    always_comb begin
        clic_node_t nodes [NumSrc];
        for (int i = 0; i < NumSrc; i++) begin
            nodes[i].valid = eligible_i[i];
            nodes[i].level = level_i[i*LevelWidth +: LevelWidth];
            nodes[i].id    = NodeIdWidth'(i);
        end
        // Reduce in place: each level folds pairs (2j, 2j+1) into slot j.
        for (int l = 0; l < Depth; l++) begin
            for (int j = 0; j < (NumSrc >> (l + 1)); j++) begin
                nodes[j] = (nodes[2*j+1] > nodes[2*j]) ? nodes[2*j+1] : nodes[2*j];
            end
        end
        valid_o = nodes[0].valid;
        level_o = nodes[0].level;
        id_o    = nodes[0].id[IdWidth-1:0];
    end

endmodule

// File: rtl/clic_irq_tx.sv
// rtl/clic_irq_tx.sv - CLIC-side transmitter: arbitrates sources and drives the core's one-hot irq
module clic_irq_tx
    import clic_pkg::*;
#(
    parameter int NumSrc     = 64,
    parameter int LevelWidth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumSrc-1:0]            pending_i,
    input  logic [NumSrc-1:0]            enable_i,
    input  logic [NumSrc-1:0]            edge_i,
    input  logic [NumSrc*LevelWidth-1:0] level_i,
    output logic [NumSrc-1:0]            clr_o,
    clic_irq_tx_if.master                core
);

    localparam int IdWidth = $clog2(NumSrc);

    logic [NumSrc-1:0]     eligible;
    logic                  win_valid;
    logic [LevelWidth-1:0] win_level;
    logic [IdWidth-1:0]    win_id;

    clic_state_e           state_q, state_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [LevelWidth-1:0] level_q, level_d;
    logic [NumSrc-1:0]     irq_q, irq_d;

    assign eligible = pending_i & enable_i;

    clic_max_tree #(
        .NumSrc  (NumSrc),
        .IdWidth (IdWidth)
    ) u_max_tree (
        .eligible_i (eligible),
        .level_i    (level_i),
        .valid_o    (win_valid),
        .level_o    (win_level),
        .id_o       (win_id)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            level_q <= '0;
            irq_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            level_q <= level_d;
            irq_q   <= irq_d;
        end
    end

    // Ack outranks withdrawal so an acknowledged interrupt always gets its clear.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    id_d    = win_id;
                    level_d = win_level;
                end
            end
            REQ: begin
                if (core.irq_ack) begin
                    state_d = CLR;
                end else if (!eligible[id_q]) begin
                    state_d = IDLE;
                end else if (win_level > level_q) begin
                    state_d = IDLE;
                end
            end
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_d = '0;
        if (state_d == REQ) begin
            irq_d[id_d] = 1'b1;
        end
        clr_o = '0;
        if ((state_q == REQ) && core.irq_ack && edge_i[id_q]) begin
            clr_o[id_q] = 1'b1;
        end
    end

    assign core.irq       = irq_q;
    assign core.irq_level = level_q;
    assign core.irq_id    = id_q;

endmodule

// File: tb/tb_clic_irq_tx.sv
// tb/tb_clic_irq_tx.sv - self-checking bench for clic_irq_tx against a behavioural model
module tb_clic_irq_tx;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   pend, en, edg, clr;
    logic [N*8-1:0] lvl;

    int errors = 0;
    int checks = 0;

    int           m_id   = -1;
    int           m_lvl  = 0;
    bit           m_cool = 1'b0;
    logic [N-1:0] last_clr = '0;

    clic_irq_tx_if #(.NumSrc(N)) core_if ();

    clic_irq_tx #(.NumSrc(N)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pending_i (pend),
        .enable_i  (en),
        .edge_i    (edg),
        .level_i   (lvl),
        .clr_o     (clr),
        .core      (core_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lv(int i);
        return int'(lvl[i*8 +: 8]);
    endfunction

    function automatic int best();
        int b = -1;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && en[i] && (b < 0 || lv(i) >= lv(b))) b = i;
        end
        return b;
    endfunction

    // Called just after inputs settle for the cycle; compares, then advances the model past the edge.
    task automatic step();
        logic [N-1:0] e_irq, e_clr;
        int b;
        #1;
        e_irq = '0;
        e_clr = '0;
        if (m_id >= 0) begin
            e_irq[m_id] = 1'b1;
            if (core_if.irq_ack && edg[m_id]) e_clr[m_id] = 1'b1;
        end
        check("irq", core_if.irq, e_irq);
        check("clr", clr, e_clr);
        if (m_id >= 0) begin
            check("irq_level", core_if.irq_level, m_lvl);
            check("irq_id", core_if.irq_id, m_id);
        end
        check("irq_onehot0", $onehot0(core_if.irq), 1);
        check("clr_count", ($countones(clr) <= 1), 1);
        last_clr = e_clr;
        b = best();
        if (m_id >= 0) begin
            if (core_if.irq_ack) begin
                m_id   = -1;
                m_cool = 1'b1;
            end else if (!(pend[m_id] && en[m_id])) begin
                m_id = -1;
            end else if (lv(b) > m_lvl) begin
                m_id = -1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (b >= 0) begin
            m_id  = b;
            m_lvl = lv(b);
        end
    endtask

    task automatic clear_inputs();
        pend = '0;
        en   = '0;
        edg  = '0;
        lvl  = '0;
        core_if.irq_ack = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            core_if.irq_ack = 1'b0;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        check("rst_irq", core_if.irq, 0);
        check("rst_level", core_if.irq_level, 0);
        check("rst_id", core_if.irq_id, 0);
        check("rst_clr", clr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        idle(2);

        // single edge source, ack and the two-cycle gap
        @(negedge clk);
        pend[5] = 1'b1; en[5] = 1'b1; edg[5] = 1'b1; lvl[5*8 +: 8] = 8'h40;
        step();
        check("t1_latency", core_if.irq, 0);
        @(negedge clk); step();
        check("t1_irq", core_if.irq, 16'h0020);
        check("t1_level", core_if.irq_level, 8'h40);
        check("t1_id", core_if.irq_id, 5);
        @(negedge clk); core_if.irq_ack = 1'b1; step();
        check("t1_clr", clr, 16'h0020);
        @(negedge clk); core_if.irq_ack = 1'b0; step();
        check("t1_gap0", core_if.irq, 0);
        @(negedge clk); step();
        check("t1_gap1", core_if.irq, 0);
        @(negedge clk); step();
        check("t1_rereq", core_if.irq, 16'h0020);
        @(negedge clk); clear_inputs(); step();
        idle(2);

        // level tie and preemption
        @(negedge clk);
        pend = 16'h1208; en = 16'h1208;
        lvl[3*8 +: 8] = 8'h80; lvl[9*8 +: 8] = 8'h80; lvl[12*8 +: 8] = 8'h7F;
        step();
        @(negedge clk); step();
        check("t2_tie_id", core_if.irq_id, 9);
        check("t2_tie_irq", core_if.irq, 16'h0200);
        @(negedge clk); lvl[12*8 +: 8] = 8'h81; step();
        check("t2_hold", core_if.irq, 16'h0200);
        @(negedge clk); step();
        check("t2_bubble", core_if.irq, 0);
        @(negedge clk); step();
        check("t2_preempt", core_if.irq, 16'h1000);
        check("t2_level", core_if.irq_level, 8'h81);
        @(negedge clk); clear_inputs(); step();
        idle(2);

        // withdrawal of a level-triggered source
        @(negedge clk); pend[7] = 1'b1; en[7] = 1'b1; lvl[7*8 +: 8] = 8'h10; step();
        @(negedge clk); step();
        check("t3_irq", core_if.irq, 16'h0080);
        @(negedge clk); pend[7] = 1'b0; step();
        @(negedge clk); step();
        check("t3_withdrawn", core_if.irq, 0);
        check("t3_noclr", clr, 0);
        @(negedge clk); pend[7] = 1'b1; step();
        @(negedge clk); step();
        check("t3_rereq", core_if.irq, 16'h0080);

        // ack collides with disable
        @(negedge clk); core_if.irq_ack = 1'b1; en[7] = 1'b0; edg[7] = 1'b1; step();
        check("t4_clr", clr, 16'h0080);
        @(negedge clk); core_if.irq_ack = 1'b0; step();
        check("t4_clr_off", core_if.irq, 0);
        idle(3);
        check("t4_no_rereq", core_if.irq, 0);

        // stray ack while idle
        @(negedge clk); core_if.irq_ack = 1'b1; step();
        check("t5_stray_clr", clr, 0);
        @(negedge clk); clear_inputs(); step();

        // asynchronous reset in the middle of a request
        @(negedge clk); pend[2] = 1'b1; en[2] = 1'b1; edg[2] = 1'b1; lvl[2*8 +: 8] = 8'h55; step();
        @(negedge clk); step();
        check("t6_req", core_if.irq, 16'h0004);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        core_if.irq_ack = 1'b1;
        #1;
        check("t6_rst_irq", core_if.irq, 0);
        check("t6_rst_level", core_if.irq_level, 0);
        check("t6_rst_clr", clr, 0);
        m_id   = -1;
        m_cool = 1'b0;
        @(negedge clk); rst_n = 1'b1; core_if.irq_ack = 1'b0; step();
        @(negedge clk); step();
        check("t6_after_rst", core_if.irq, 16'h0004);
        @(negedge clk); clear_inputs(); step();
        idle(2);

        // randomised traffic; acknowledged edge sources lose their pending bit
        en  = N'($urandom) | N'($urandom);
        edg = N'($urandom);
        for (int i = 0; i < N; i++) lvl[i*8 +: 8] = 8'($urandom_range(0, 3) * 64);
        for (int c = 0; c < 2000; c++) begin
            int k;
            @(negedge clk);
            pend = pend & ~last_clr;
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, N - 1);
                pend[k] = ~pend[k];
            end
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, N - 1);
                en[k] = ~en[k];
            end
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, N - 1);
                lvl[k*8 +: 8] = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 1));
            end
            core_if.irq_ack = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clic_irq_tx.md
Name: clic_irq_tx

Overview:
- Interrupt-controller-side transmitter for the core's one-hot CLIC interrupt interface.
- Selects the highest-level eligible source and presents it to the core as a one-hot request plus an 8-bit level.
- Holds the request stable until the core's ack handshake arrives, then clears edge-triggered pending state.
- Sits in the CLIC, directly driving the core's irq/irq_level inputs and consuming its irq_ack output.

Parameters:
- NumSrc, 64, number of interrupt sources (≥2, power of two); one-hot output width.
- LevelWidth, 8, interrupt level width; fixed to 8 to match the core interface.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- pending_i  input  NumSrc  per-source pending bit (clicintip).
- enable_i  input  NumSrc  per-source enable (clicintie).
- edge_i  input  NumSrc  1 = edge-triggered source (pending cleared on ack); 0 = level-triggered.
- level_i  input  NumSrc*8  per-source level; source i at [8i+7:8i].
- irq_o  output  NumSrc  one-hot request to the core; zero means no request.
- irq_level_o  output  8  level of the requested source.
- irq_ack_i  input  1  core acknowledge; single-cycle pulse.
- clr_o  output  NumSrc  one-cycle pulse clearing pending for the acknowledged edge source.
- irq_id_o  output  $clog2(NumSrc)  id of the current request, for the claim/debug CSR.

Behaviour:
- Eligibility: eligible[i] = pending_i[i] & enable_i[i].
- Arbitration (combinational): highest level_i wins; on a level tie, the higher id wins.
- Winner is valid iff any eligible source exists.
- FSM states: IDLE, REQ, CLR.
- IDLE:
  - If a winner is valid, register winner id and level and go to REQ.
  - irq_o becomes one-hot on the next cycle, so latency is 1 cycle from eligible to request.
- REQ:
  - irq_o = onehot(id_q), irq_level_o = level_q; both held stable.
  - irq_ack_i=1 → go to CLR. In the same cycle, clr_o[id_q] pulses if edge_i[id_q]=1.
  - Otherwise, if eligible[id_q]=0 (source dropped or was disabled) → withdraw: irq_o=0 next cycle, go to IDLE.
  - Otherwise, if the current winner's level is strictly greater than level_q → withdraw and go to IDLE (preemption). Re-arbitration follows, with exactly one bubble cycle in which irq_o=0.
  - Simultaneous ack and withdrawal/preemption: ack wins (go to CLR, pulse clr_o).
- CLR:
  - irq_o=0 for one cycle so the cleared pending bit propagates before re-arbitration.
  - Go to IDLE unconditionally.
  - Back-to-back requests are therefore separated by at least 2 zero cycles after an ack.
- irq_ack_i outside REQ is ignored; no clr_o pulse.
- irq_o is never multi-hot.
- clr_o is zero except during the single ack cycle.
- Level register: stores level_i at win time. Later changes to level_i are not reflected until re-arbitration; level_i changes are not a withdrawal cause.
- Reset (async, any state): FSM=IDLE; irq_o=0, irq_level_o=0, irq_id_o=0, clr_o=0.
- Outputs irq_o, irq_level_o and irq_id_o are registered. clr_o is combinational from state, id_q and irq_ack_i.
- NumSrc=2 corner case: the arbitration tree reduces to a single compare.

Decomposition:
- Shared package (clic_pkg):
  - LevelWidth constant.
  - clic_state_e enum (IDLE, REQ, CLR).
  - Typedef for the {id, level, valid} arbitration node.
- Sub-module clic_max_tree:
  - Parameterised log2(NumSrc)-deep binary max-tree over {valid, level, id} nodes.
  - Comparison: valid first, then level, then id. Purely combinational.
- The FSM and output registers stay in clic_irq_tx.

Test Plan:
- Single source: pending[5]=1, en[5]=1, edge[5]=1, level[5]=0x40 → cycle+1 irq_o=1<<5, irq_level_o=0x40, irq_id_o=5. Ack → clr_o=1<<5 the same cycle, then irq_o=0 for ≥2 cycles.
- Priority and tie: src3 and src9 at level 0x80, src12 at 0x7F → id 9 selected. Raise src12 to 0x81 during REQ → one cycle of irq_o=0, then irq_o=1<<12.
- Withdrawal: level-triggered src7 requested; drop pending[7] without ack → irq_o=0 next cycle, no clr_o pulse, FSM back in IDLE.
- Ack/withdraw collision: in the same cycle, ack is pulsed and enable[7] cleared → clr_o pulses only if edge[7]=1, FSM→CLR, no spurious re-request.
- Stray ack and reset: ack in IDLE → no clr_o. Assert rst_ni low mid-REQ → irq_o/irq_level_o/clr_o=0 immediately. Release with a source pending → request 1 cycle after the first clock edge.
- Randomised check with a one-hot assertion on irq_o; irq_o and irq_level_o stable throughout REQ; $countones(clr_o)≤1.
